pll_reset_sequencer: RTL and testbench
======================================

// Module: pll_reset_sequencer
// PURPOSE
//  Sequences bring-up of the 3-output system PLL (114.545/57.273/28.636 MHz) from the 50 MHz refclk.
//  Pulses the PLL reset, waits for and qualifies lock, then releases per-clock-domain resets in order.
//  Watches for loss of lock, retries on acquisition timeout and latches a fault after repeated failures.
//  Sits beside the PLL wrapper in the top level; dom_rst[] feeds each domain's own reset synchronizer.
// PARAMETERS
//  RST_CYCLES     16     cycles pll_rst is held high per attempt (>=1)
//  LOCK_TIMEOUT   50000  max cycles from pll_rst release to qualified lock (1 ms @ 50 MHz)
//  STABLE_CYCLES  1024   consecutive synced-lock cycles required before releasing resets
//  RELEASE_GAP    8      cycles between successive dom_rst deassertions (>=1)
//  NUM_DOMAINS    3      number of downstream reset outputs; bit i pairs with outclk_i
//  MAX_RETRIES    7      timeouts tolerated before FAULT (1..15)
//  CNT_W          16     counter width; every cycle parameter must be < 2**CNT_W
// PORTS
//  refclk      in   1            50 MHz reference clock; sole clock of this block
//  rst         in   1            synchronous, active-high reset
//  pll_locked  in   1            PLL locked flag, asynchronous to refclk
//  reinit      in   1            one-cycle request to restart the full sequence
//  pll_rst     out  1            reset to PLL
//  dom_rst     out  NUM_DOMAINS  per-domain reset, active high, refclk-registered
//  ready       out  1            all domains released, lock held
//  lock_lost   out  1            one-cycle pulse: lock dropped in RELEASE or RUN
//  fault       out  1            sticky: MAX_RETRIES timeouts exhausted
//  retry_cnt   out  4            timeouts in current bring-up, saturating at MAX_RETRIES
//  state_dbg   out  3            encoded FSM state for debug
// BEHAVIOUR
//  - rst=1 at an edge: state=PLL_RST, counters 0, pll_rst=1, dom_rst=all 1, ready=0,
//    lock_lost=0, fault=0, retry_cnt=0. rst applied mid-sequence behaves identically.
//  - pll_locked -> 2-flop synchronizer -> lock_s (2-cycle latency); only lock_s is used.
//  - All outputs registered. Encoding: PLL_RST=0 WAIT_LOCK=1 STABLE=2 RELEASE=3 RUN=4 FAULT=5.
//  - PLL_RST: pll_rst=1 for exactly RST_CYCLES cycles, then WAIT_LOCK; timeout counter cleared.
//  - WAIT_LOCK: pll_rst=0; timeout counter increments every cycle in WAIT_LOCK and STABLE.
//    lock_s=1 -> STABLE (stable counter cleared). Counter reaching LOCK_TIMEOUT-1 -> timeout.
//  - STABLE: lock_s=0 -> back to WAIT_LOCK, timeout counter NOT cleared (bounds acquisition).
//    STABLE_CYCLES consecutive cycles with lock_s=1 -> RELEASE.
//  - Timeout: retry_cnt+1; if new value == MAX_RETRIES -> FAULT, else PLL_RST.
//    Same-cycle lock_s=1 and timeout: lock wins.
//  - RELEASE: dom_rst[0] falls on the entry edge; dom_rst[i] falls RELEASE_GAP cycles after
//    dom_rst[i-1]. ready rises on the same edge as dom_rst[NUM_DOMAINS-1]; state -> RUN.
//  - RUN: holds. retry_cnt cleared on entry to RUN.
//  - lock_s=0 in RELEASE or RUN: next edge dom_rst=all 1, ready=0, lock_lost=1 for one
//    cycle, state -> PLL_RST; retry_cnt unchanged.
//  - FAULT: pll_rst=1, dom_rst=all 1, ready=0, fault=1; exits only on reinit or rst.
//  - reinit=1 in any state: same as rst except synchronizer contents kept; wins over every
//    same-cycle event (timeout, lock loss, RELEASE step).
//  - dom_rst never deasserts while pll_rst=1; deassertion order is always 0..NUM_DOMAINS-1.
// TESTING  (RST_CYCLES=4 LOCK_TIMEOUT=20 STABLE_CYCLES=8 RELEASE_GAP=2 NUM_DOMAINS=3 MAX_RETRIES=2)
//  1 rst 3 cycles, locked rises 6 cycles later and stays -> pll_rst high exactly 4 cycles;
//    dom_rst[0] falls 10 edges after first edge sampling locked=1, [1] at +2, [2] and ready at +4.
//  2 locked never rises -> two 4-cycle pll_rst pulses 20 cycles apart; after 2nd timeout
//    FAULT: fault=1, retry_cnt=2, pll_rst=1, dom_rst=3'b111.
//  3 in RUN drop locked 1 cycle -> lock_lost single pulse, dom_rst=3'b111, ready=0,
//    pll_rst re-pulses; locked back -> full sequence completes again, retry_cnt=0.
//  4 locked toggles every 5 cycles in STABLE -> never reaches RELEASE; timeout after 20
//    cycles total since pll_rst release; retry_cnt=1.
//  5 reinit in FAULT, and reinit same cycle as lock loss in RUN -> PLL_RST, fault=0,
//    retry_cnt=0, lock_lost stays 0.
//  6 rst asserted mid-RELEASE after dom_rst[0] fell -> next edge all reset values restored.

Source files
------------

// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - PLL bring-up, lock qualification and ordered per-domain reset release
module pll_reset_sequencer #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int STABLE_CYCLES = 1024,
    parameter int RELEASE_GAP   = 8,
    parameter int NUM_DOMAINS   = 3,
    parameter int MAX_RETRIES   = 7,
    parameter int CNT_W         = 16
) (
    input  logic                   refclk,
    input  logic                   rst,
    input  logic                   pll_locked,
    input  logic                   reinit,
    output logic                   pll_rst,
    output logic [NUM_DOMAINS-1:0] dom_rst,
    output logic                   ready,
    output logic                   lock_lost,
    output logic                   fault,
    output logic [3:0]             retry_cnt,
    output logic [2:0]             state_dbg
);
    typedef enum logic [2:0] {
        S_PLL_RST   = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RELEASE   = 3'd3,
        S_RUN       = 3'd4,
        S_FAULT     = 3'd5
    } state_t;

    localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    localparam logic [CNT_W-1:0]       CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]       RST_LAST  = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]       TMO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]       STB_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]       GAP_LAST  = CNT_W'(RELEASE_GAP - 1);
    localparam logic [3:0]             RETRY_MAX = 4'(MAX_RETRIES);
    localparam logic [IDX_W-1:0]       IDX_ONE   = IDX_W'(1);
    localparam logic [IDX_W-1:0]       IDX_LAST  = IDX_W'(NUM_DOMAINS - 1);
    localparam logic [NUM_DOMAINS-1:0] ALL_ON    = '1;
    localparam logic [NUM_DOMAINS-1:0] FIRST_OFF = ALL_ON << 1;

    state_t           state;
    logic             sync_q;
    logic             lock_s;
    logic [CNT_W-1:0] cnt;        // shared: reset pulse, stable run, release gap
    logic [CNT_W-1:0] tmo_cnt;
    logic [IDX_W-1:0] rel_idx;
    logic [3:0]       retry_nxt;

    assign retry_nxt = retry_cnt + 4'd1;
    assign state_dbg = state;

    // reinit deliberately leaves the synchronizer alone; only rst clears it
    always_ff @(posedge refclk) begin
        if (rst) begin
            sync_q <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            sync_q <= pll_locked;
            lock_s <= sync_q;
        end
    end

    always_ff @(posedge refclk) begin
        if (rst || reinit) begin
            state     <= S_PLL_RST;
            cnt       <= '0;
            tmo_cnt   <= '0;
            rel_idx   <= '0;
            pll_rst   <= 1'b1;
            dom_rst   <= ALL_ON;
            ready     <= 1'b0;
            lock_lost <= 1'b0;
            fault     <= 1'b0;
            retry_cnt <= 4'd0;
        end else begin
            lock_lost <= 1'b0;
            case (state)
                S_PLL_RST: begin
                    pll_rst <= 1'b1;
                    if (cnt == RST_LAST) begin
                        state   <= S_WAIT_LOCK;
                        pll_rst <= 1'b0;
                        cnt     <= '0;
                        tmo_cnt <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                S_WAIT_LOCK, S_STABLE: begin
                    tmo_cnt <= tmo_cnt + CNT_ONE;
                    if (state == S_WAIT_LOCK && lock_s) begin
                        state <= S_STABLE;
                        cnt   <= '0;
                    end else if (state == S_STABLE && lock_s && cnt == STB_LAST) begin
                        state   <= S_RELEASE;
                        cnt     <= '0;
                        rel_idx <= IDX_ONE;
                        dom_rst <= FIRST_OFF;
                        if (NUM_DOMAINS == 1) begin
                            ready     <= 1'b1;
                            state     <= S_RUN;
                            retry_cnt <= 4'd0;
                        end
                    end else if (tmo_cnt >= TMO_LAST) begin
                        retry_cnt <= retry_nxt;
                        pll_rst   <= 1'b1;
                        cnt       <= '0;
                        if (retry_nxt == RETRY_MAX) begin
                            state <= S_FAULT;
                            fault <= 1'b1;
                        end else begin
                            state <= S_PLL_RST;
                        end
                    end else if (!lock_s) begin
                        // timeout counter keeps running so flapping lock still times out
                        state <= S_WAIT_LOCK;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                S_RELEASE, S_RUN: begin
                    if (!lock_s) begin
                        state     <= S_PLL_RST;
                        cnt       <= '0;
                        pll_rst   <= 1'b1;
                        dom_rst   <= ALL_ON;
                        ready     <= 1'b0;
                        lock_lost <= 1'b1;
                    end else if (state == S_RELEASE) begin
                        if (cnt == GAP_LAST) begin
                            cnt              <= '0;
                            dom_rst[rel_idx] <= 1'b0;
                            rel_idx          <= rel_idx + IDX_ONE;
                            if (rel_idx == IDX_LAST) begin
                                ready     <= 1'b1;
                                state     <= S_RUN;
                                retry_cnt <= 4'd0;
                            end
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                end
                S_FAULT: begin
                    pll_rst <= 1'b1;
                    dom_rst <= ALL_ON;
                    ready   <= 1'b0;
                    fault   <= 1'b1;
                end
                default: begin
                    state   <= S_PLL_RST;
                    cnt     <= '0;
                    pll_rst <= 1'b1;
                    dom_rst <= ALL_ON;
                    ready   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb/tb_pll_reset_sequencer.sv - scoreboard bench for pll_reset_sequencer
module tb_pll_reset_sequencer;
    localparam int N = 3;

    logic         refclk = 1'b0;
    logic         rst = 1'b1;
    logic         pll_locked = 1'b0;
    logic         reinit = 1'b0;
    logic         pll_rst;
    logic [N-1:0] dom_rst;
    logic         ready;
    logic         lock_lost;
    logic         fault;
    logic [3:0]   retry_cnt;
    logic [2:0]   state_dbg;

    pll_reset_sequencer #(
        .RST_CYCLES(4), .LOCK_TIMEOUT(20), .STABLE_CYCLES(8), .RELEASE_GAP(2),
        .NUM_DOMAINS(N), .MAX_RETRIES(2), .CNT_W(16)
    ) dut (
        .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .reinit(reinit),
        .pll_rst(pll_rst), .dom_rst(dom_rst), .ready(ready), .lock_lost(lock_lost),
        .fault(fault), .retry_cnt(retry_cnt), .state_dbg(state_dbg)
    );

    always #10 refclk = ~refclk;

    // {pll_rst, dom_rst[2:0], ready, lock_lost, fault}
    localparam logic [6:0] RSTV  = 7'b1111000;
    localparam logic [6:0] WLV   = 7'b0111000;
    localparam logic [6:0] REL0  = 7'b0110000;
    localparam logic [6:0] REL1  = 7'b0100000;
    localparam logic [6:0] RUNV  = 7'b0000100;
    localparam logic [6:0] LOSTV = 7'b1111010;
    localparam logic [6:0] FLTV  = 7'b1111001;

    typedef struct {
        int         c;
        logic [6:0] obs;
        int         r;
        int         s;
        int         tag;
    } ev_t;

    ev_t q[$];
    int  cyc = 0;
    int  compared = 0;
    int  mismatched = 0;

    always @(posedge refclk) cyc++;

    // Every change of the observable output vector must match the next queued event.
    logic [6:0] prev;
    bit         first = 1'b1;
    always @(posedge refclk) begin
        logic [6:0] obs;
        ev_t        e;
        #1;
        obs = {pll_rst, dom_rst, ready, lock_lost, fault};
        if (first || obs != prev) begin
            compared++;
            if (q.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_change: cyc=%0d got obs=%b retry=%0d state=%0d, required no change from %b",
                         cyc, obs, retry_cnt, state_dbg, prev);
            end else begin
                e = q.pop_front();
                if (e.c != cyc || e.obs != obs || e.r != int'(retry_cnt) || e.s != int'(state_dbg)) begin
                    mismatched++;
                    $display("FAIL ev%0d: got cyc=%0d obs=%b retry=%0d state=%0d, required cyc=%0d obs=%b retry=%0d state=%0d",
                             e.tag, cyc, obs, retry_cnt, state_dbg, e.c, e.obs, e.r, e.s);
                end
            end
        end
        first = 1'b0;
        prev  = obs;
    end

    task automatic ex(input int c, input logic [6:0] o, input int r, input int s, input int tag);
        ev_t e;
        e.c = c; e.obs = o; e.r = r; e.s = s; e.tag = tag;
        q.push_back(e);
    endtask

    task automatic at(input int n);
        while (cyc < n) @(negedge refclk);
    endtask

    initial begin
        // 1: power-on reset, lock 6 cycles after release, full bring-up
        ex(1, RSTV, 0, 0, 10); ex(7, WLV, 0, 1, 11); ex(20, REL0, 0, 3, 12);
        ex(22, REL1, 0, 3, 13); ex(24, RUNV, 0, 4, 14);
        at(3);  rst = 1'b0;
        at(9);  pll_locked = 1'b1;

        // 3: one-cycle lock drop in RUN, then full re-sequence
        ex(31, LOSTV, 0, 0, 30); ex(32, RSTV, 0, 0, 31); ex(35, WLV, 0, 1, 32);
        ex(44, REL0, 0, 3, 33); ex(46, REL1, 0, 3, 34); ex(48, RUNV, 0, 4, 35);
        at(28); pll_locked = 1'b0;
        at(29); pll_locked = 1'b1;

        // 5b: reinit on the same edge that sees lock loss in RUN
        ex(55, RSTV, 0, 0, 50); ex(59, WLV, 0, 1, 51);
        at(52); pll_locked = 1'b0;
        at(54); reinit = 1'b1;
        at(55); reinit = 1'b0;

        // 4: lock flapping every 5 cycles during acquisition, then lock gone -> FAULT
        ex(79, RSTV, 1, 0, 40); ex(83, WLV, 1, 1, 41); ex(103, FLTV, 2, 5, 42);
        at(59); pll_locked = 1'b1;
        at(64); pll_locked = 1'b0;
        at(69); pll_locked = 1'b1;
        at(74); pll_locked = 1'b0;

        // 2: reset, lock never comes -> two timeouts -> FAULT
        ex(107, RSTV, 0, 0, 20); ex(113, WLV, 0, 1, 21); ex(133, RSTV, 1, 0, 22);
        ex(137, WLV, 1, 1, 23); ex(157, FLTV, 2, 5, 24);
        at(106); rst = 1'b1;
        at(109); rst = 1'b0;

        // 5a: reinit out of FAULT, lock present, run up to first release
        ex(161, RSTV, 0, 0, 55); ex(165, WLV, 0, 1, 56); ex(174, REL0, 0, 3, 57);
        at(160); reinit = 1'b1;
        at(161); reinit = 1'b0; pll_locked = 1'b1;

        // 6: rst mid-RELEASE, then re-sequence from a cleared synchronizer
        ex(175, RSTV, 0, 0, 60); ex(179, WLV, 0, 1, 61); ex(188, REL0, 0, 3, 62);
        ex(190, REL1, 0, 3, 63); ex(192, RUNV, 0, 4, 64);
        at(174); rst = 1'b1;
        at(175); rst = 1'b0;

        at(205);
        compared++;
        if (q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: got %0d events still pending (next ev%0d at cyc %0d), required 0",
                     q.size(), q[0].tag, q[0].c);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
